// File: rtl/ace_seq_pkg.sv
// Shared types and constants for the actuator control-loop sequencer.
package ace_seq_pkg;

  // Encoding is visible on state_o, so the values must stay fixed.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_SPI_START = 3'd2,
    S_SPI_WAIT  = 3'd3,
    S_FILT      = 3'd4,
    S_PI        = 3'd5,
    S_DONE      = 3'd6
  } seq_state_t;

  localparam int unsigned SEQ_ADC_LEN = 12;
  localparam int unsigned SEQ_HDR_W   = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned width_of(input int unsigned v);
    return (v > 32'd2) ? $clog2(v) : 32'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-period tick generator: counts 0..SAMPLE_PERIOD_CLKS-1 while enabled
// and pulses tick_o for one clock at the terminal count.
module tick_gen
  import ace_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD_CLKS = 5000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW   = width_of(SAMPLE_PERIOD_CLKS);
  localparam logic [CW-1:0] TERM = CW'(SAMPLE_PERIOD_CLKS - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    if (!en_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == TERM) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/ctrl_loop_sequencer.sv
// Control-loop sequencer: one ordered SPI -> filter -> PI -> telemetry
// transaction per sample tick, with stage timeouts and sticky error flags.
module ctrl_loop_sequencer
  import ace_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD_CLKS = 5000,
  parameter int unsigned FRAME_LEN          = SEQ_ADC_LEN + SEQ_HDR_W,
  parameter int unsigned ADC_DATA_LEN       = SEQ_ADC_LEN,
  parameter int unsigned SPI_TIMEOUT_CLKS   = 1024,
  parameter int unsigned STAGE_TIMEOUT_CLKS = 256,
  parameter int unsigned UART_DECIM         = 16
) (
  input  logic                    clk_i,
  input  logic                    Reset_i,
  input  logic                    Enable_i,
  input  logic                    clear_err_i,
  output logic                    spi_start_o,
  input  logic                    spi_busy_i,
  input  logic                    spi_data_ready_i,
  input  logic [FRAME_LEN-1:0]    spi_rx_data_i,
  output logic                    filt_valid_o,
  output logic [ADC_DATA_LEN-1:0] filt_data_o,
  input  logic                    filt_done_i,
  output logic                    pi_start_o,
  input  logic                    pi_done_i,
  output logic                    uart_req_o,
  output logic [ADC_DATA_LEN-1:0] uart_data_o,
  input  logic                    uart_busy_i,
  output logic                    overrun_o,
  output logic                    timeout_o,
  output logic                    frame_err_o,
  output logic [15:0]             sample_cnt_o,
  output logic [2:0]              state_o
);

  localparam int unsigned HDR_W = FRAME_LEN - ADC_DATA_LEN;
  localparam int unsigned TMR_W = width_of(max_u(SPI_TIMEOUT_CLKS, STAGE_TIMEOUT_CLKS));
  localparam logic [TMR_W-1:0] SPI_LIM = TMR_W'(SPI_TIMEOUT_CLKS - 1);
  localparam logic [TMR_W-1:0] STG_LIM = TMR_W'(STAGE_TIMEOUT_CLKS - 1);
  localparam int unsigned DEC_W = width_of(UART_DECIM);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(UART_DECIM - 1);

  seq_state_t              state_d, state_q;
  logic [TMR_W-1:0]        timer_d, timer_q;
  logic [DEC_W-1:0]        decim_d, decim_q;
  logic                    spi_start_d, spi_start_q;
  logic                    filt_valid_d, filt_valid_q;
  logic                    pi_start_d, pi_start_q;
  logic                    uart_req_d, uart_req_q;
  logic [ADC_DATA_LEN-1:0] filt_data_d, filt_data_q;
  logic [ADC_DATA_LEN-1:0] uart_data_d, uart_data_q;
  logic [15:0]             sample_cnt_d, sample_cnt_q;
  logic                    overrun_d, overrun_q;
  logic                    timeout_d, timeout_q;
  logic                    frame_err_d, frame_err_q;
  logic                    set_ovr_s, set_to_s, set_fe_s;
  logic                    tick_s;
  logic                    hdr_ok_s;

  tick_gen #(
    .SAMPLE_PERIOD_CLKS(SAMPLE_PERIOD_CLKS)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_i (Reset_i),
    .en_i  (Enable_i),
    .tick_o(tick_s)
  );

  assign hdr_ok_s = (spi_rx_data_i[FRAME_LEN-1:ADC_DATA_LEN] == {HDR_W{1'b0}});

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    decim_d      = decim_q;
    spi_start_d  = 1'b0;
    filt_valid_d = 1'b0;
    pi_start_d   = 1'b0;
    uart_req_d   = 1'b0;
    filt_data_d  = filt_data_q;
    uart_data_d  = uart_data_q;
    sample_cnt_d = sample_cnt_q;
    set_to_s     = 1'b0;
    set_fe_s     = 1'b0;

    // Ticks are never queued: one outside WAIT_TICK is only reported.
    if (tick_s && (state_q != S_WAIT_TICK)) begin
      set_ovr_s = 1'b1;
    end else begin
      set_ovr_s = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (Enable_i) begin
          state_d = S_WAIT_TICK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_TICK: begin
        if (!Enable_i) begin
          state_d = S_IDLE;
        end else if (tick_s) begin
          // Issue the start on entry when the master is free, so the pulse
          // lands exactly one clock after the tick.
          state_d     = S_SPI_START;
          timer_d     = {TMR_W{1'b0}};
          spi_start_d = !spi_busy_i;
        end else begin
          state_d = S_WAIT_TICK;
        end
      end

      S_SPI_START: begin
        timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        if (timer_q == SPI_LIM) begin
          set_to_s = 1'b1;
          state_d  = S_DONE;
        end else if (spi_start_q) begin
          state_d = S_SPI_WAIT;
        end else if (!spi_busy_i) begin
          spi_start_d = 1'b1;
        end else begin
          state_d = S_SPI_START;
        end
      end

      S_SPI_WAIT: begin
        timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        if (spi_data_ready_i) begin
          if (hdr_ok_s) begin
            state_d      = S_FILT;
            timer_d      = {TMR_W{1'b0}};
            filt_valid_d = 1'b1;
            filt_data_d  = spi_rx_data_i[ADC_DATA_LEN-1:0];
            sample_cnt_d = sample_cnt_q + 16'd1;
          end else begin
            set_fe_s = 1'b1;
            state_d  = S_DONE;
          end
        end else if (timer_q == SPI_LIM) begin
          set_to_s = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_SPI_WAIT;
        end
      end

      S_FILT: begin
        timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        if (filt_done_i) begin
          state_d    = S_PI;
          timer_d    = {TMR_W{1'b0}};
          pi_start_d = 1'b1;
        end else if (timer_q == STG_LIM) begin
          set_to_s = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_FILT;
        end
      end

      S_PI: begin
        timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        if (pi_done_i) begin
          state_d = S_DONE;
          // A busy transmitter forfeits this telemetry slot; decimation restarts.
          if (decim_q == DEC_LAST) begin
            decim_d = {DEC_W{1'b0}};
            if (!uart_busy_i) begin
              uart_req_d  = 1'b1;
              uart_data_d = filt_data_q;
            end else begin
              uart_req_d = 1'b0;
            end
          end else begin
            decim_d = decim_q + {{(DEC_W-1){1'b0}}, 1'b1};
          end
        end else if (timer_q == STG_LIM) begin
          set_to_s = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_PI;
        end
      end

      S_DONE: begin
        state_d = S_WAIT_TICK;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky flags: a set on the same clock as a clear wins.
  always_comb begin
    if (set_ovr_s) begin
      overrun_d = 1'b1;
    end else if (clear_err_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (set_to_s) begin
      timeout_d = 1'b1;
    end else if (clear_err_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    if (set_fe_s) begin
      frame_err_d = 1'b1;
    end else if (clear_err_i) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  always_ff @(posedge clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q      <= S_IDLE;
      timer_q      <= {TMR_W{1'b0}};
      decim_q      <= {DEC_W{1'b0}};
      spi_start_q  <= 1'b0;
      filt_valid_q <= 1'b0;
      pi_start_q   <= 1'b0;
      uart_req_q   <= 1'b0;
      filt_data_q  <= {ADC_DATA_LEN{1'b0}};
      uart_data_q  <= {ADC_DATA_LEN{1'b0}};
      sample_cnt_q <= 16'd0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      decim_q      <= decim_d;
      spi_start_q  <= spi_start_d;
      filt_valid_q <= filt_valid_d;
      pi_start_q   <= pi_start_d;
      uart_req_q   <= uart_req_d;
      filt_data_q  <= filt_data_d;
      uart_data_q  <= uart_data_d;
      sample_cnt_q <= sample_cnt_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign spi_start_o  = spi_start_q;
  assign filt_valid_o = filt_valid_q;
  assign filt_data_o  = filt_data_q;
  assign pi_start_o   = pi_start_q;
  assign uart_req_o   = uart_req_q;
  assign uart_data_o  = uart_data_q;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;
  assign frame_err_o  = frame_err_q;
  assign sample_cnt_o = sample_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ctrl_loop_sequencer.sv
// Directed and randomized bench for ctrl_loop_sequencer against a
// transaction-level model of one loop iteration per tick.
module tb_ctrl_loop_sequencer;

  localparam int PERIOD = 100;
  localparam int DECIM  = 4;
  localparam int SPI_TO = 1024;
  localparam int STG_TO = 256;

  logic        clk = 1'b0;
  logic        Reset_i = 1'b1;
  logic        Enable_i = 1'b0;
  logic        clear_err_i = 1'b0;
  logic        spi_start_o;
  logic        spi_busy_i = 1'b0;
  logic        spi_data_ready_i = 1'b0;
  logic [14:0] spi_rx_data_i = 15'd0;
  logic        filt_valid_o;
  logic [11:0] filt_data_o;
  logic        filt_done_i = 1'b0;
  logic        pi_start_o;
  logic        pi_done_i = 1'b0;
  logic        uart_req_o;
  logic [11:0] uart_data_o;
  logic        uart_busy_i = 1'b0;
  logic        overrun_o;
  logic        timeout_o;
  logic        frame_err_o;
  logic [15:0] sample_cnt_o;
  logic [2:0]  state_o;

  ctrl_loop_sequencer #(
    .SAMPLE_PERIOD_CLKS(PERIOD),
    .FRAME_LEN(15),
    .ADC_DATA_LEN(12),
    .SPI_TIMEOUT_CLKS(SPI_TO),
    .STAGE_TIMEOUT_CLKS(STG_TO),
    .UART_DECIM(DECIM)
  ) dut (
    .clk_i(clk), .Reset_i(Reset_i), .Enable_i(Enable_i), .clear_err_i(clear_err_i),
    .spi_start_o(spi_start_o), .spi_busy_i(spi_busy_i),
    .spi_data_ready_i(spi_data_ready_i), .spi_rx_data_i(spi_rx_data_i),
    .filt_valid_o(filt_valid_o), .filt_data_o(filt_data_o), .filt_done_i(filt_done_i),
    .pi_start_o(pi_start_o), .pi_done_i(pi_done_i),
    .uart_req_o(uart_req_o), .uart_data_o(uart_data_o), .uart_busy_i(uart_busy_i),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .frame_err_o(frame_err_o),
    .sample_cnt_o(sample_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_spi = 0, n_fv = 0, n_pi = 0, n_uart = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spi_start_o)  n_spi  <= n_spi + 1;
    if (filt_valid_o) n_fv   <= n_fv + 1;
    if (pi_start_o)   n_pi   <= n_pi + 1;
    if (uart_req_o)   n_uart <= n_uart + 1;
  end

  int n_checks = 0, n_fail = 0;
  logic [15:0] m_cnt = 16'd0;
  logic [11:0] m_code = 12'd0, m_uart = 12'd0;
  int m_decim = 0, m_spi = 0, m_fv = 0, m_pi = 0, m_ureq = 0;
  int last_start = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_spi_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (spi_start_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_timeout(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      @(negedge clk);
      if (timeout_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err_i = 1'b1;
    @(negedge clk); clear_err_i = 1'b0;
  endtask

  // One loop iteration; a negative latency means that response never comes.
  task automatic run_sample(input logic [14:0] frame, input int sbusy, input int spi_lat,
                            input int filt_lat, input int pi_lat, input bit ubusy);
    bit ok, seen, exp_req;
    int t0;
    if (sbusy > 0) begin
      spi_busy_i = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
        @(negedge clk);
        if (state_o === 3'd2) ok = 1'b1;
      end
      chk("busy_state_spi_start", ok, 1);
      seen = 1'b0;
      repeat (sbusy) begin
        @(negedge clk);
        if (spi_start_o) seen = 1'b1;
      end
      chk("busy_holds_start", seen, 0);
      spi_busy_i = 1'b0;
      @(negedge clk);
      ok = spi_start_o;
    end else begin
      wait_spi_start(ok);
    end
    chk("spi_start_seen", ok, 1);
    if (!ok) return;
    m_spi++;
    t0 = cyc;
    last_start = cyc;
    @(negedge clk);
    chk("spi_start_width", spi_start_o, 0);
    if (spi_lat < 0) begin
      wait_timeout(SPI_TO + 100, ok);
      chk("spi_timeout_seen", ok, 1);
      chk("spi_timeout_latency", cyc - t0, SPI_TO);
      return;
    end
    repeat (spi_lat - 1) @(negedge clk);
    spi_rx_data_i = frame;
    spi_data_ready_i = 1'b1;
    @(negedge clk);
    spi_data_ready_i = 1'b0;
    if (frame[14:12] != 3'd0) begin
      chk("frame_err_set", frame_err_o, 1);
      chk("frame_err_no_valid", filt_valid_o, 0);
      chk("frame_err_cnt_hold", sample_cnt_o, m_cnt);
      return;
    end
    m_cnt = m_cnt + 16'd1;
    m_code = frame[11:0];
    m_fv++;
    chk("filt_valid", filt_valid_o, 1);
    chk("filt_data", filt_data_o, m_code);
    chk("sample_cnt", sample_cnt_o, m_cnt);
    t0 = cyc;
    if (filt_lat < 0) begin
      wait_timeout(STG_TO + 100, ok);
      chk("stage_timeout_seen", ok, 1);
      chk("stage_timeout_latency", cyc - t0, STG_TO);
      return;
    end
    repeat (filt_lat) @(negedge clk);
    filt_done_i = 1'b1;
    @(negedge clk);
    filt_done_i = 1'b0;
    m_pi++;
    chk("pi_start", pi_start_o, 1);
    repeat (pi_lat) @(negedge clk);
    uart_busy_i = ubusy;
    pi_done_i = 1'b1;
    @(negedge clk);
    pi_done_i = 1'b0;
    uart_busy_i = 1'b0;
    m_decim++;
    exp_req = 1'b0;
    if (m_decim == DECIM) begin
      m_decim = 0;
      if (!ubusy) begin
        exp_req = 1'b1;
        m_uart = m_code;
        m_ureq++;
      end
    end
    chk("uart_req", uart_req_o, exp_req);
    chk("uart_data", uart_data_o, m_uart);
  endtask

  task automatic chk_totals();
    @(negedge clk);
    @(negedge clk);
    chk("total_spi_start", n_spi, m_spi);
    chk("total_filt_valid", n_fv, m_fv);
    chk("total_pi_start", n_pi, m_pi);
    chk("total_uart_req", n_uart, m_ureq);
  endtask

  initial begin
    bit ok;
    int p0, u0, pulses;
    logic [14:0] fr;

    repeat (3) @(negedge clk);
    chk("reset_flags", {spi_start_o, filt_valid_o, pi_start_o, uart_req_o,
                        overrun_o, timeout_o, frame_err_o}, 0);
    chk("reset_data", {filt_data_o, uart_data_o, sample_cnt_o}, 0);
    chk("reset_state", state_o, 3'd0);
    Reset_i = 1'b0;
    @(negedge clk);
    chk("idle_while_disabled", state_o, 3'd0);
    Enable_i = 1'b1;
    @(negedge clk);
    chk("wait_tick_on_enable", state_o, 3'd1);

    // Nominal frames with done returned two clocks after each start.
    run_sample(15'h0800, 0, 2, 1, 1, 1'b0);
    p0 = last_start;
    run_sample(15'h0800, 0, 2, 1, 1, 1'b0);
    chk("tick_period", last_start - p0, PERIOD);
    run_sample(15'h0800, 0, 2, 1, 1, 1'b0);
    chk_totals();

    run_sample(15'h4A14, 0, 2, 1, 1, 1'b0);
    pulse_clear();
    chk("frame_err_cleared", frame_err_o, 0);

    run_sample(15'h0000, 0, -1, 0, 0, 1'b0);
    chk("timeout_sticky", timeout_o, 1);
    chk("overrun_during_timeout", overrun_o, 1);
    run_sample(15'h0123, 0, 2, 1, 1, 1'b0);
    pulse_clear();
    chk("errors_cleared", {overrun_o, timeout_o}, 0);

    run_sample(15'h0ABC, 0, 2, -1, 0, 1'b0);
    pulse_clear();
    chk("stage_timeout_cleared", timeout_o, 0);

    run_sample(15'h0555, 0, 2, 1, 150, 1'b0);
    chk("overrun_set", overrun_o, 1);
    chk_totals();

    // Asynchronous reset while waiting for the SPI frame.
    wait_spi_start(ok);
    chk("reset_test_start", ok, 1);
    if (ok) m_spi++;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_state", state_o, 3'd3);
    #2 Reset_i = 1'b1;
    #1;
    chk("async_reset_flags", {spi_start_o, filt_valid_o, pi_start_o, uart_req_o,
                              overrun_o, timeout_o, frame_err_o}, 0);
    chk("async_reset_data", {filt_data_o, uart_data_o, sample_cnt_o}, 0);
    chk("async_reset_state", state_o, 3'd0);
    repeat (2) @(negedge clk);
    Reset_i = 1'b0;
    m_cnt = 16'd0; m_decim = 0; m_uart = 12'd0;
    @(negedge clk);
    chk("release_state", state_o, 3'd1);
    pulses = 0;
    repeat (4) begin
      pulses += int'(spi_start_o) + int'(filt_valid_o) + int'(pi_start_o) + int'(uart_req_o);
      @(negedge clk);
    end
    chk("no_stale_pulse", pulses, 0);
    chk_totals();

    // Decimation: sample 4 meets a busy transmitter, so only sample 8 is sent.
    u0 = m_ureq;
    for (int i = 1; i <= 8; i++) begin
      fr = {3'd0, 12'($urandom)};
      run_sample(fr, 0, 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), (i == 4));
    end
    chk("decim_one_request", m_ureq - u0, 1);
    chk_totals();

    for (int i = 0; i < 16; i++) begin
      fr = 15'($urandom);
      if ($urandom_range(0, 3) != 0) fr[14:12] = 3'd0;
      run_sample(fr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
                 int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    chk_totals();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
